// File: rtl/als_mon_pkg.sv
// als_mon_pkg
// Shared types and helpers for the approximate-adder error monitor.
//   mon_state_e  : run-control FSM states
//   DEF_*        : default widths for operands, counters and the accumulator
//   sat_add()    : unsigned add clamped to the all-ones value of a given width
package als_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } mon_state_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 32;
  localparam int DEF_ACC_W = 64;

  // Widest accumulator sat_add() can serve; callers zero-extend into it.
  localparam int SAT_MAX_W = 128;

  // Returns min(acc + inc, 2^w - 1). Both operands must already fit in w bits.
  function automatic logic [SAT_MAX_W-1:0] sat_add(
    input logic [SAT_MAX_W-1:0] acc,
    input logic [SAT_MAX_W-1:0] inc,
    input int                   w
  );
    logic [SAT_MAX_W:0] one;
    logic [SAT_MAX_W:0] lim;
    logic [SAT_MAX_W:0] s;
    one = {{SAT_MAX_W{1'b0}}, 1'b1};
    lim = (one << w) - one;
    s   = {1'b0, acc} + {1'b0, inc};
    return (s > lim) ? lim[SAT_MAX_W-1:0] : s[SAT_MAX_W-1:0];
  endfunction

endpackage

// File: rtl/als_err_dist.sv
// als_err_dist
// Registered error-distance stage for an approximate adder of any width.
// Computes the exact sum a+b (WIDTH+1 bits, never wraps) and the unsigned
// distance to the approximate sum, one cycle after the inputs are presented.
//   clk, rst_n       : clock, async active-low reset
//   flush            : drops the in-flight valid bit
//   in_valid         : a/b/sum present
//   a, b             : operands (WIDTH)
//   sum              : approximate sum (WIDTH+1)
//   out_valid        : ed/mismatch are valid
//   ed               : |exact - sum| (WIDTH+1)
//   mismatch         : ed != 0
module als_err_dist
  import als_mon_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH:0]   sum,
  output logic             out_valid,
  output logic [WIDTH:0]   ed,
  output logic             mismatch
);

  logic [WIDTH:0] exact;
  logic [WIDTH:0] ed_c;

  always_comb begin
    exact = {1'b0, a} + {1'b0, b};
    ed_c  = (exact >= sum) ? (exact - sum) : (sum - exact);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      ed        <= '0;
      mismatch  <= 1'b0;
    end else begin
      out_valid <= in_valid && !flush;
      if (in_valid) begin
        ed       <= ed_c;
        mismatch <= (ed_c != '0);
      end
    end
  end

endmodule

// File: rtl/als_error_monitor.sv
// als_error_monitor
// Accumulates error statistics of an approximate adder over a run of
// num_samples operand/sum triples: error count, max and summed error distance.
//   clk, rst_n                 : clock, async active-low reset
//   start, clear, num_samples  : run control
//   in_valid/in_ready          : sample handshake
//   in_a, in_b, in_sum         : operands and approximate sum
//   busy, done                 : run status
//   sample_count, err_count    : processed samples, samples with error
//   max_ed, sum_ed             : max and saturating sum of |exact - approx|
//
// state | meaning
// IDLE  | waiting for start; statistics from the last run remain readable
// RUN   | accepting samples until target transfers have occurred
// DRAIN | no new samples; waiting for S1/S2 to empty into the statistics
// DONE  | run complete; statistics stable
module als_error_monitor
  import als_mon_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH:0]   in_sum,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] err_count,
  output logic [WIDTH:0]   max_ed,
  output logic [ACC_W-1:0] sum_ed
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  mon_state_e state, state_nxt;

  logic [CNT_W-1:0] accepted;
  logic [CNT_W-1:0] target;
  logic             transfer;
  logic             last_xfer;
  logic             start_run;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH:0]   s1_sum;

  logic             s2_valid;
  logic [WIDTH:0]   s2_ed;
  logic             s2_mismatch;

  // in_ready depends only on registered state, never on in_valid.
  assign in_ready  = (state == ST_RUN) && (accepted < target);
  assign transfer  = in_valid && in_ready && !clear;
  assign last_xfer = transfer && ((accepted + CNT_ONE) == target);
  assign busy      = (state == ST_RUN) || (state == ST_DRAIN);
  assign done      = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_run = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          start_run = 1'b1;
          state_nxt = (num_samples == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_xfer) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        // S3 commits on the edge that empties S2, so both valids low means
        // the final statistics are already in the output registers.
        if (!s1_valid && !s2_valid) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (clear) begin
      state_nxt = ST_IDLE;
      start_run = 1'b0;
    end
  end

  // S1: operand capture and run bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sum   <= '0;
      accepted <= '0;
      target   <= '0;
    end else if (clear) begin
      s1_valid <= 1'b0;
      accepted <= '0;
      target   <= '0;
    end else if (start_run) begin
      s1_valid <= 1'b0;
      accepted <= '0;
      target   <= num_samples;
    end else begin
      s1_valid <= transfer;
      if (transfer) begin
        s1_a     <= in_a;
        s1_b     <= in_b;
        s1_sum   <= in_sum;
        accepted <= accepted + CNT_ONE;
      end
    end
  end

  // S2: exact sum and error distance.
  als_err_dist #(.WIDTH(WIDTH)) u_err_dist (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (clear),
    .in_valid  (s1_valid),
    .a         (s1_a),
    .b         (s1_b),
    .sum       (s1_sum),
    .out_valid (s2_valid),
    .ed        (s2_ed),
    .mismatch  (s2_mismatch)
  );

  // S3: statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_count <= '0;
      err_count    <= '0;
      max_ed       <= '0;
      sum_ed       <= '0;
    end else if (clear || start_run) begin
      sample_count <= '0;
      err_count    <= '0;
      max_ed       <= '0;
      sum_ed       <= '0;
    end else if (s2_valid) begin
      sample_count <= sample_count + CNT_ONE;
      err_count    <= err_count + {{(CNT_W-1){1'b0}}, s2_mismatch};
      if (s2_ed > max_ed) max_ed <= s2_ed;
      sum_ed <= ACC_W'(sat_add(SAT_MAX_W'(sum_ed), SAT_MAX_W'(s2_ed), ACC_W));
    end
  end

endmodule

// File: doc/als_error_monitor.md
Name: als_error_monitor

Overview:
- Response-side counterpart to the operand-driving bench flow: consumes operand pairs plus the sum produced by an approximate 32-bit adder under test, and computes the exact sum internally.
- Accumulates error statistics in hardware for approximate-logic-synthesis characterisation runs: error count, maximum error distance and summed error distance.
- Sits between the adder wrapper and a readout/CSR block; replaces offline post-processing of dumped outputs.

Parameters:
- WIDTH, 32, operand width; sums are WIDTH+1 bits
- CNT_W, 32, width of sample target and sample/error counters
- ACC_W, 64, width of the summed-error-distance accumulator

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; begin a run of num_samples samples
- clear  in  1  pulse; abort run, return to IDLE, zero all statistics
- num_samples  in  CNT_W  sample target, sampled on the start cycle
- in_valid  in  1  sample present
- in_ready  out  1  monitor accepts the sample this cycle
- in_a  in  WIDTH  operand 0
- in_b  in  WIDTH  operand 1
- in_sum  in  WIDTH+1  approximate sum from the adder under test
- busy  out  1  state is RUN or DRAIN
- done  out  1  state is DONE
- sample_count  out  CNT_W  samples fully processed
- err_count  out  CNT_W  samples with in_sum != in_a+in_b
- max_ed  out  WIDTH+1  maximum |exact - approx|
- sum_ed  out  ACC_W  sum of |exact - approx|, saturating

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; all outputs 0; pipeline valid bits 0; target register 0.
- Handshake:
  - A sample transfers when in_valid && in_ready.
  - in_ready = (state==RUN) && (accepted < target); it is a registered-state function only, with no combinational path from in_valid.
- Pipeline, 3 stages:
  - S1 registers a, b, sum and a valid bit on transfer.
  - S2 computes exact = a+b, which is WIDTH+1 bits zero-extended and never wraps. It also computes ed = |exact - in_sum| (WIDTH+1 bits, unsigned magnitude) and mismatch = (ed != 0).
  - S3 updates the statistics.
  - Latency: a sample accepted at edge t appears in the statistics outputs after edge t+2.
- Statistics update per valid S3 sample:
  - sample_count += 1.
  - err_count += mismatch.
  - max_ed = max(max_ed, ed).
  - sum_ed += ed, saturating at 2^ACC_W-1 (no wrap).
  - The counters cannot exceed target, so they never overflow.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE:
    - start -> zero all statistics and accepted; target=num_samples; go to RUN.
    - If num_samples==0, go to DONE directly instead.
  - RUN:
    - Accept samples.
    - When the transfer that makes accepted==target occurs, go to DRAIN next cycle.
    - start is ignored.
  - DRAIN:
    - in_ready=0.
    - Go to DONE on the first cycle where the S1 and S2 valid bits are both 0 and the last S3 update is committed; this is typically 2 cycles.
  - DONE:
    - done=1; statistics held stable.
    - start -> behaves exactly as start in IDLE.
- clear in any state:
  - Next state IDLE; statistics and accepted zeroed; pipeline valid bits cleared, with in-flight samples discarded.
  - clear wins over a simultaneous start.
  - A transfer in the same cycle as clear is discarded.
- in_valid while not ready: ignored; no statistic changes.
- Statistics outputs are registered and glitch-free, and remain readable in IDLE until the next start or clear.

Decomposition:
- Package als_mon_pkg:
  - state enum (IDLE, RUN, DRAIN, DONE)
  - default width constants
  - a saturating-add helper function
- One natural sub-module: als_err_dist. It is the registered S2 stage: a, b, sum in -> ed, mismatch out, with a valid passthrough, and is reusable for other approximate adder widths.
- The FSM and accumulators stay in the top module.

Test Plan:
- Reset mid-RUN: after 3 accepted samples with a mismatch, pull rst_n low asynchronously -> all outputs 0 immediately, no clock needed; in_ready=0.
- Exact adder, start with num_samples=4 on pairs (1,2,3), (0xFFFFFFFF,1,0x100000000), (0,0,0), (0xFFFFFFFF,0xFFFFFFFF,0x1FFFFFFFE) -> done; sample_count=4, err_count=0, max_ed=0, sum_ed=0.
- Errors: num_samples=3 with (10,5,13), (0x80000000,0x80000000,0), (7,7,14) -> err_count=2, max_ed=0x100000000, sum_ed=0x100000002.
- Backpressure and limit: num_samples=2 with in_valid held high for 5 cycles -> exactly 2 transfers; in_ready low afterwards; done asserted 3 cycles after the 2nd transfer; start pulses during RUN are ignored.
- Edge cases:
  - start with num_samples=0 -> done next cycle, counters 0.
  - clear and start in the same cycle -> IDLE, counters 0.
- Saturation: ACC_W=8 override; 3 samples each with ed=100 -> sum_ed=255, max_ed=100, err_count=3.
